// File: rtl/sbc_led_activity_if.sv
// Front-panel activity lamp signals: raw strobes and switch levels in, stretched lamp byte out.
interface sbc_led_activity_if;
  logic [7:0] events;
  logic       lamp_test;
  logic       freeze;
  logic [7:0] fbarSbcLeds;

  modport master (
    output events,
    output lamp_test,
    output freeze,
    input  fbarSbcLeds
  );

  modport slave (
    input  events,
    input  lamp_test,
    input  freeze,
    output fbarSbcLeds
  );
endinterface

// File: rtl/sbc_led_activity.sv
// Activity lamp driver: synchronizes eight CPU/SBC strobes and stretches each into a
// visible lamp pulse using a shared tick prescaler, with lamp-test and freeze switches.
module sbc_led_activity #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int HOLD_TICKS = 50
) (
  input  logic              pll0_50MHz,
  input  logic              n_reset,
  sbc_led_activity_if.slave bus
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int CW       = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_TICKS);

  logic [7:0]    evMeta, evSync;
  logic          ltMeta, ltSync;
  logic          fzMeta, fzSync;
  logic [PW-1:0] preCnt;
  logic          tick;
  logic [CW-1:0] holdCnt [8];
  logic [7:0]    ledReg;

  // Two-flop synchronizers; strobes and switches may be asynchronous to the clock.
  always_ff @(posedge pll0_50MHz or negedge n_reset) begin
    if (!n_reset) begin
      evMeta <= '0;
      evSync <= '0;
      ltMeta <= 1'b0;
      ltSync <= 1'b0;
      fzMeta <= 1'b0;
      fzSync <= 1'b0;
    end else begin
      evMeta <= bus.events;
      evSync <= evMeta;
      ltMeta <= bus.lamp_test;
      ltSync <= ltMeta;
      fzMeta <= bus.freeze;
      fzSync <= fzMeta;
    end
  end

  // Freeze stops the stretch clock as well, so the display resumes with its phase intact.
  assign tick = !fzSync && (preCnt == TICK_LAST);

  always_ff @(posedge pll0_50MHz or negedge n_reset) begin
    if (!n_reset) begin
      preCnt <= '0;
    end else if (!fzSync) begin
      preCnt <= tick ? '0 : preCnt + PW'(1);
    end
  end

  // Level load beats the tick decrement, so a held or colliding event restarts the full stretch.
  always_ff @(posedge pll0_50MHz or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 8; i++) begin
        holdCnt[i] <= '0;
      end
    end else if (!fzSync) begin
      for (int i = 0; i < 8; i++) begin
        if (evSync[i]) begin
          holdCnt[i] <= HOLD_LOAD;
        end else if (tick && (holdCnt[i] != '0)) begin
          holdCnt[i] <= holdCnt[i] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge pll0_50MHz or negedge n_reset) begin
    if (!n_reset) begin
      ledReg <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        ledReg[i] <= ltSync | (holdCnt[i] != '0);
      end
    end
  end

  assign bus.fbarSbcLeds = ledReg;

endmodule
